// File: rtl/sum_pkg.sv
// Shared types and constants for the triangular-number inverse block.
//   state_t      : FSM state encoding
//   *_DEF        : default widths for target/remainder and n
//   DIGIT_BASE   : decimal base used when splitting n into digits
//   SEG_*        : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
package sum_pkg;

  localparam int unsigned TARGET_W_DEF = 11;
  localparam int unsigned N_W_DEF      = 6;
  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SEG_W        = 7;
  localparam int unsigned DIGIT_BASE   = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SUBTRACT = 3'd2,
    ST_DIGITS   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decimal digit to active-low 7-segment decoder.
//   digit      : 4-bit BCD digit (codes above 9 blank the display)
//   segments_c : active-low {g,f,e,d,c,b,a}
module seg7_decoder
  import sum_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   segments_c
);

  always_comb begin
    segments_c = SEG_BLANK;
    case (digit)
      4'd0:    segments_c = SEG_0;
      4'd1:    segments_c = SEG_1;
      4'd2:    segments_c = SEG_2;
      4'd3:    segments_c = SEG_3;
      4'd4:    segments_c = SEG_4;
      4'd5:    segments_c = SEG_5;
      4'd6:    segments_c = SEG_6;
      4'd7:    segments_c = SEG_7;
      4'd8:    segments_c = SEG_8;
      4'd9:    segments_c = SEG_9;
      default: segments_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_inverse.sv
// Finds the largest n with 0+1+..+n <= target by repeated subtraction and
// reports n, the leftover, an exact-hit flag and n as two 7-seg digits.
//   clk, rst         : clock, asynchronous active-low reset
//   start            : level request, accepted in IDLE or DONE
//   step_en          : paces SUBTRACT and DIGITS iterations
//   target           : S, captured when start is accepted
//   status_indicator : bit0 busy, bit1 done
//   n_out, remainder, exact, display_units, display_decenas : results,
//                      updated only when DONE is entered
module sum_inverse
  import sum_pkg::*;
#(
  parameter int unsigned TARGET_W = TARGET_W_DEF,
  parameter int unsigned N_W      = N_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step_en,
  input  logic [TARGET_W-1:0] target,
  output logic [1:0]          status_indicator,
  output logic [N_W-1:0]      n_out,
  output logic [TARGET_W-1:0] remainder,
  output logic                exact,
  output logic [SEG_W-1:0]    display_units,
  output logic [SEG_W-1:0]    display_decenas
);

  // k runs one past the largest n, so it needs one extra bit
  localparam int unsigned K_W = N_W + 1;

  state_t              state, state_next;
  logic [TARGET_W-1:0] target_q, target_q_next;
  logic [TARGET_W-1:0] rem, rem_next;
  logic [K_W-1:0]      k, k_next;
  logic [N_W-1:0]      n, n_next;
  logic [N_W-1:0]      ones, ones_next;
  logic [DIGIT_W-1:0]  tens, tens_next;
  logic [1:0]          status_next;
  logic [N_W-1:0]      n_out_next;
  logic [TARGET_W-1:0] remainder_next;
  logic                exact_next;
  logic [SEG_W-1:0]    units_next, decenas_next;
  logic [SEG_W-1:0]    seg_units_c, seg_tens_c;

  // Decoders look at the working digits; their outputs are only
  // captured on the DIGITS->DONE edge, when ones is already below 10.
  seg7_decoder u_seg_units (
    .digit      (DIGIT_W'(ones)),
    .segments_c (seg_units_c)
  );

  seg7_decoder u_seg_tens (
    .digit      (tens),
    .segments_c (seg_tens_c)
  );

  // Next-state, datapath and result-update logic
  always_comb begin
    state_next     = state;
    target_q_next  = target_q;
    rem_next       = rem;
    k_next         = k;
    n_next         = n;
    ones_next      = ones;
    tens_next      = tens;
    n_out_next     = n_out;
    remainder_next = remainder;
    exact_next     = exact;
    units_next     = display_units;
    decenas_next   = display_decenas;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          target_q_next = target;
          state_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rem_next   = target_q;
        k_next     = K_W'(1);
        n_next     = '0;
        state_next = ST_SUBTRACT;
      end
      ST_SUBTRACT: begin
        if (step_en) begin
          if (rem >= TARGET_W'(k)) begin
            rem_next = rem - TARGET_W'(k);
            n_next   = N_W'(k);
            k_next   = k + K_W'(1);
          end else begin
            ones_next  = n;
            tens_next  = '0;
            state_next = ST_DIGITS;
          end
        end
      end
      ST_DIGITS: begin
        if (step_en) begin
          if (ones >= N_W'(DIGIT_BASE)) begin
            ones_next = ones - N_W'(DIGIT_BASE);
            tens_next = tens + DIGIT_W'(1);
          end else begin
            state_next     = ST_DONE;
            n_out_next     = n;
            remainder_next = rem;
            exact_next     = (rem == '0);
            units_next     = seg_units_c;
            decenas_next   = seg_tens_c;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Status tracks the state being entered so it is aligned with it
    status_next = {(state_next == ST_DONE),
                   (state_next inside {ST_LOAD, ST_SUBTRACT, ST_DIGITS})};
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      target_q         <= '0;
      rem              <= '0;
      k                <= '0;
      n                <= '0;
      ones             <= '0;
      tens             <= '0;
      status_indicator <= 2'b00;
      n_out            <= '0;
      remainder        <= '0;
      exact            <= 1'b0;
      display_units    <= SEG_0;
      display_decenas  <= SEG_0;
    end else begin
      state            <= state_next;
      target_q         <= target_q_next;
      rem              <= rem_next;
      k                <= k_next;
      n                <= n_next;
      ones             <= ones_next;
      tens             <= tens_next;
      status_indicator <= status_next;
      n_out            <= n_out_next;
      remainder        <= remainder_next;
      exact            <= exact_next;
      display_units    <= units_next;
      display_decenas  <= decenas_next;
    end
  end

endmodule

// File: tb/tb_sum_inverse.sv
// Self-checking bench for sum_inverse: directed and random targets
// compared against a triangular-number reference model.
module tb_sum_inverse;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        step_en = 1'b1;
  logic [10:0] target = '0;
  logic [1:0]  status_indicator;
  logic [5:0]  n_out;
  logic [10:0] remainder;
  logic        exact;
  logic [6:0]  display_units;
  logic [6:0]  display_decenas;

  int vectors = 0;
  int miscompares = 0;
  int prev_n = 0;
  int prev_r = 0;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  sum_inverse dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .step_en          (step_en),
    .target           (target),
    .status_indicator (status_indicator),
    .n_out            (n_out),
    .remainder        (remainder),
    .exact            (exact),
    .display_units    (display_units),
    .display_decenas  (display_decenas)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Largest n with n(n+1)/2 <= s, and what is left over
  function automatic void model(input int s, output int n, output int r);
    n = 0;
    while ((n + 1) * (n + 2) / 2 <= s) n++;
    r = s - n * (n + 1) / 2;
  endfunction

  // mode: 0 step_en high, 1 toggling, 2 random.  hold keeps start high.
  // poke re-pulses start with another target mid-computation.
  task automatic run(input int s, input int mode, input bit hold, input bit poke);
    int  n, r, need, e, w;
    bit  mdone, ddone;
    model(s, n, r);
    need = (n + 1) + (n / 10 + 1);   // enabled SUBTRACT + DIGITS edges
    @(negedge clk);
    target  = 11'(s);
    start   = 1'b1;
    step_en = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_on_accept", 32'(status_indicator), 32'(2'b01));
    chk("n_held_busy", 32'(n_out), 32'(prev_n));
    chk("rem_held_busy", 32'(remainder), 32'(prev_r));
    e = 0; w = 0; mdone = 0; ddone = 0;
    while (!mdone && !ddone && e < 400) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      target = 11'($urandom_range(0, 2047));
      case (mode)
        0:       step_en = 1'b1;
        1:       step_en = (e % 2 == 0);
        default: step_en = 1'($urandom_range(0, 1));
      endcase
      if (poke && e == 2) begin
        start  = 1'b1;
        target = 11'(s ^ 32'h155);
      end
      @(posedge clk);
      e++;
      if (e > 1 && step_en) w++;   // first edge is LOAD, never gated
      mdone = (w == need);
      #1;
      ddone = status_indicator[1];
    end
    chk("no_timeout", 32'(e < 400), 32'd1);
    chk("done_timing", 32'(ddone), 32'(mdone));
    if (mode == 0) chk("latency", 32'(e), 32'(n + n / 10 + 3));
    chk("status_done", 32'(status_indicator), 32'(2'b10));
    chk("n_out", 32'(n_out), 32'(n));
    chk("remainder", 32'(remainder), 32'(r));
    chk("exact", 32'(exact), 32'(r == 0));
    chk("units", 32'(display_units), 32'(seg_ref[n % 10]));
    chk("decenas", 32'(display_decenas), 32'(seg_ref[n / 10]));
    prev_n = n;
    prev_r = r;
    step_en = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_status"}, 32'(status_indicator), 32'd0);
    chk({tag, "_n"}, 32'(n_out), 32'd0);
    chk({tag, "_rem"}, 32'(remainder), 32'd0);
    chk({tag, "_exact"}, 32'(exact), 32'd0);
    chk({tag, "_units"}, 32'(display_units), 32'(7'b1000000));
    chk({tag, "_decenas"}, 32'(display_decenas), 32'(7'b1000000));
  endtask

  initial begin
    #12;
    chk_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    run(0, 0, 0, 0);
    run(10, 0, 0, 0);
    run(20, 0, 0, 0);
    run(2047, 0, 0, 0);
    run(15, 1, 0, 0);
    run(100, 0, 0, 1);
    run(36, 0, 1, 0);   // start stays high: completes then restarts
    run(36, 0, 0, 0);
    for (int i = 0; i < 8; i++) run(int'($urandom_range(0, 2047)), 2, 0, 0);
    run(2047, 1, 0, 0);

    // Abort mid-SUBTRACT
    @(negedge clk);
    target = 11'd2047;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_reset_values("abort");
    @(negedge clk);
    rst = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(status_indicator), 32'd0);
    prev_n = 0;
    prev_r = 0;
    run(3, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
